// File: rtl/fp_normalizer_pipe.sv
// Two-stage normaliser between the FP adder mantissa sum and result packing.
// Define ROUND_EN to round the carry path to nearest-even; otherwise that path truncates.
module fp_normalizer_pipe #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W:0]   sum_result,
  input  logic [EXP_W-1:0]  exponent_in,
  input  logic              overflow_flag,
  input  logic              in_sticky,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] mantissa_out,
  output logic [EXP_W-1:0]  exponent_out,
  output logic              overflow,
  output logic              underflow,
  output logic              zero,
  output logic [CNT_W-1:0]  ovf_count,
  output logic [CNT_W-1:0]  unf_count,
  input  logic              clr_cnt
);

  localparam int LZ_W = $clog2(MANT_W + 1);
  localparam int CW   = (EXP_W > LZ_W) ? EXP_W : LZ_W;
`ifdef ROUND_EN
  localparam logic RND_EN = 1'b1;
`else
  localparam logic RND_EN = 1'b0;
`endif

  logic              s1_valid_q;
  logic [MANT_W:0]   s1_sum_q;
  logic [EXP_W-1:0]  s1_exp_q;
  logic              s1_ovf_q;
  logic              s1_sticky_q;
  logic [LZ_W-1:0]   s1_lz_q;
  logic [LZ_W-1:0]   lz_d;

  logic              out_valid_q;
  logic [MANT_W-1:0] mant_q, mant_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic              ovf_q, ovf_d, unf_q, unf_d, zero_q, zero_d;
  logic [CNT_W-1:0]  ovf_cnt_q, unf_cnt_q;

  logic s1_adv;
  logic out_xfer;

  assign s1_adv   = !out_valid_q | out_ready;
  assign in_ready = !s1_valid_q | s1_adv;
  assign out_xfer = out_valid_q & out_ready;

  // Highest set bit wins, so the scan runs LSB to MSB.
  always_comb begin
    lz_d = LZ_W'(MANT_W);
    for (int i = 0; i < MANT_W; i++) begin
      if (sum_result[i]) lz_d = LZ_W'(MANT_W - 1 - i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_sum_q    <= '0;
      s1_exp_q    <= '0;
      s1_ovf_q    <= 1'b0;
      s1_sticky_q <= 1'b0;
      s1_lz_q     <= '0;
    end else if (in_ready) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_sum_q    <= sum_result;
        s1_exp_q    <= exponent_in;
        s1_ovf_q    <= overflow_flag;
        s1_sticky_q <= in_sticky;
        s1_lz_q     <= lz_d;
      end
    end
  end

  logic              zero_c, carry_c, rnd_c, ovf_c, normal_c;
  logic [MANT_W-1:0] mant_t, mant_c, low_c;
  logic [MANT_W:0]   mant_r;
  logic [EXP_W:0]    exp_c;
  logic [CW-1:0]     exp_ext, lz_ext;

  assign low_c    = s1_sum_q[MANT_W-1:0];
  assign zero_c   = (s1_sum_q == '0);
  assign carry_c  = s1_sum_q[MANT_W] | s1_ovf_q;
  assign mant_t   = s1_sum_q[MANT_W:1];
  assign rnd_c    = RND_EN & s1_sum_q[0] & (s1_sticky_q | mant_t[0]);
  assign mant_r   = {1'b0, mant_t} + (MANT_W+1)'(rnd_c);
  // A rounding carry-out renormalises to 1.000... and bumps the exponent once more.
  assign exp_c    = {1'b0, s1_exp_q} + (EXP_W+1)'(1) + (EXP_W+1)'(mant_r[MANT_W]);
  assign mant_c   = mant_r[MANT_W] ? {1'b1, {(MANT_W-1){1'b0}}} : mant_r[MANT_W-1:0];
  assign ovf_c    = (exp_c >= {1'b0, {EXP_W{1'b1}}});
  assign exp_ext  = CW'(s1_exp_q);
  assign lz_ext   = CW'(s1_lz_q);
  assign normal_c = (exp_ext > lz_ext);

  always_comb begin
    mant_d = '0;
    exp_d  = '0;
    ovf_d  = 1'b0;
    unf_d  = 1'b0;
    zero_d = 1'b0;
    if (zero_c) begin
      zero_d = 1'b1;
    end else if (carry_c) begin
      if (ovf_c) begin
        ovf_d = 1'b1;
        exp_d = '1;
      end else begin
        exp_d  = exp_c[EXP_W-1:0];
        mant_d = mant_c;
      end
    end else if (normal_c) begin
      exp_d  = EXP_W'(exp_ext - lz_ext);
      mant_d = low_c << s1_lz_q;
    end else begin
      unf_d  = 1'b1;
      mant_d = (s1_exp_q == '0) ? low_c : (low_c << (s1_exp_q - EXP_W'(1)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      mant_q      <= '0;
      exp_q       <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else if (s1_adv) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        mant_q <= mant_d;
        exp_q  <= exp_d;
        ovf_q  <= ovf_d;
        unf_q  <= unf_d;
        zero_q <= zero_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt_q <= '0;
      unf_cnt_q <= '0;
    end else if (clr_cnt) begin
      ovf_cnt_q <= '0;
      unf_cnt_q <= '0;
    end else if (out_xfer) begin
      if (ovf_q && (ovf_cnt_q != '1)) ovf_cnt_q <= ovf_cnt_q + CNT_W'(1);
      if (unf_q && (unf_cnt_q != '1)) unf_cnt_q <= unf_cnt_q + CNT_W'(1);
    end
  end

  assign out_valid    = out_valid_q;
  assign mantissa_out = mant_q;
  assign exponent_out = exp_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;
  assign zero         = zero_q;
  assign ovf_count    = ovf_cnt_q;
  assign unf_count    = unf_cnt_q;

endmodule

// File: tb/tb_fp_normalizer_pipe.sv
// Bench for fp_normalizer_pipe: value-level reference model plus directed vectors.
module tb_fp_normalizer_pipe;
  localparam int MW = 24;
  localparam int EW = 8;
  localparam int CW = 4;
`ifdef ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          in_valid = 1'b0, in_ready;
  logic [MW:0]   sum_result = '0;
  logic [EW-1:0] exponent_in = '0, exponent_out;
  logic          overflow_flag = 1'b0, in_sticky = 1'b0;
  logic          out_valid, out_ready = 1'b1;
  logic [MW-1:0] mantissa_out;
  logic          overflow, underflow, zero;
  logic [CW-1:0] ovf_count, unf_count;
  logic          clr_cnt = 1'b0;

  fp_normalizer_pipe #(.MANT_W(MW), .EXP_W(EW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .sum_result(sum_result), .exponent_in(exponent_in), .overflow_flag(overflow_flag),
    .in_sticky(in_sticky), .out_valid(out_valid), .out_ready(out_ready),
    .mantissa_out(mantissa_out), .exponent_out(exponent_out), .overflow(overflow),
    .underflow(underflow), .zero(zero), .ovf_count(ovf_count), .unf_count(unf_count),
    .clr_cnt(clr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] m;
    logic [7:0]  e;
    logic        o, u, z;
  } res_t;

  res_t exp_q[$];
  int   m_ovf = 0, m_unf = 0;
  int   n_chk = 0, n_fail = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference: the real-number meaning of each rule, not the datapath structure.
  function automatic res_t model(logic [24:0] s, logic [7:0] e, logic of, logic st);
    res_t   r;
    int     low, lz, ex;
    longint m;
    r   = '0;
    low = int'(s[23:0]);
    if (s == 0) begin
      r.z = 1'b1;
    end else if (s[24] || of) begin
      ex = int'(e) + 1;
      m  = longint'(s >> 1);
      if (RND && s[0] && (st || s[1])) m = m + 1;
      if (m == (longint'(1) << 24)) begin
        m  = longint'(1) << 23;
        ex = ex + 1;
      end
      if (ex >= 255) begin
        r.o = 1'b1;
        r.e = 8'hFF;
      end else begin
        r.e = 8'(ex);
        r.m = 24'(m);
      end
    end else begin
      lz = 24 - $clog2(low + 1);
      if (int'(e) > lz) begin
        r.e = 8'(int'(e) - lz);
        r.m = 24'(low << lz);
      end else begin
        r.u = 1'b1;
        r.m = (e == 0) ? 24'(low) : 24'(low << (int'(e) - 1));
      end
    end
    return r;
  endfunction

  always @(negedge clk) begin
    res_t r;
    if (!rst_n) begin
      exp_q.delete();
      m_ovf = 0;
      m_unf = 0;
    end else begin
      chk("ovf_count", ovf_count, m_ovf);
      chk("unf_count", unf_count, m_unf);
      r = '0;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out_valid", out_valid, 0);
        end else begin
          r = exp_q[0];
          chk("mantissa", mantissa_out, r.m);
          chk("exponent", exponent_out, r.e);
          chk("overflow", overflow, r.o);
          chk("underflow", underflow, r.u);
          chk("zero", zero, r.z);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (clr_cnt) begin
        m_ovf = 0;
        m_unf = 0;
      end else if (out_valid && out_ready) begin
        if (r.o && m_ovf < 15) m_ovf++;
        if (r.u && m_unf < 15) m_unf++;
      end
      if (in_valid && in_ready)
        exp_q.push_back(model(sum_result, exponent_in, overflow_flag, in_sticky));
    end
  end

  task automatic send(logic [24:0] s, logic [7:0] e, logic of, logic st);
    bit ok = 0;
    sum_result = s; exponent_in = e; overflow_flag = of; in_sticky = st; in_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) chk("send_timeout", ok, 1);
  endtask

  // Waits for the next output beat right after an accepted input and checks it literally.
  task automatic expect_out(string name, logic [23:0] m, logic [7:0] e, logic o, logic u, logic z);
    int lat = 0;
    bit got = 0;
    for (int i = 1; i <= 8 && !got; i++) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1;
        lat = i;
      end
    end
    chk({name, "_latency"}, lat, 2);
    chk({name, "_mant"}, mantissa_out, m);
    chk({name, "_exp"}, exponent_out, e);
    chk({name, "_flags"}, {overflow, underflow, zero}, {o, u, z});
    @(posedge clk);
    #1;
  endtask

  task automatic pin(string name, res_t act, res_t req);
    chk(name, act, req);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_mant", mantissa_out, 0);
    chk("rst_exp", exponent_out, 0);
    chk("rst_flags", {overflow, underflow, zero}, 3'b000);
    chk("rst_counts", {ovf_count, unf_count}, 0);

    pin("model_t1", model(25'h0800000, 8'h80, 0, 0), {24'h800000, 8'h80, 3'b000});
    pin("model_t4", model(25'h0000100, 8'h0A, 0, 0), {24'h020000, 8'h00, 3'b010});
    pin("model_t3", model(25'h1000000, 8'hFE, 0, 0), {24'h000000, 8'hFF, 3'b100});
    pin("model_t6", model(25'h1FFFFFF, 8'h80, 0, 0),
        RND ? {24'h800000, 8'h82, 3'b000} : {24'hFFFFFF, 8'h81, 3'b000});

    send(25'h0800000, 8'h80, 0, 0); expect_out("t1", 24'h800000, 8'h80, 0, 0, 0);
    send(25'h1000000, 8'h7F, 0, 0); expect_out("t2", 24'h800000, 8'h80, 0, 0, 0);
    send(25'h0000000, 8'h55, 1, 0); expect_out("zero", 24'h0, 8'h00, 0, 0, 1);
    send(25'h0000100, 8'h80, 0, 0); expect_out("norm_shift", 24'h800000, 8'h71, 0, 0, 0);
    send(25'h0800001, 8'h10, 1, 0); expect_out("ovf_flag_carry", 24'h400000, 8'h11, 0, 0, 0);
    send(25'h0000123, 8'h00, 0, 0); expect_out("unf_exp0", 24'h000123, 8'h00, 0, 1, 0);
    send(25'h0000100, 8'h0A, 0, 0); expect_out("t4", 24'h020000, 8'h00, 0, 1, 0);
    chk("t4_unf_count", unf_count, 2);
    send(25'h1FFFFFF, 8'h80, 0, 0);
    if (RND) expect_out("t6", 24'h800000, 8'h82, 0, 0, 0);
    else     expect_out("t6", 24'hFFFFFF, 8'h81, 0, 0, 0);

    send(25'h1000000, 8'hFE, 0, 0); expect_out("t3", 24'h0, 8'hFF, 1, 0, 0);
    chk("t3_ovf_count", ovf_count, 1);
    for (int i = 0; i < 17; i++) send(25'h1000000, 8'hFE, 0, 0);
    repeat (4) @(posedge clk);
    #1 chk("t3_ovf_sat", ovf_count, 4'hF);
    clr_cnt = 1'b1;
    @(posedge clk);
    #1 clr_cnt = 1'b0;
    chk("t3_clr_ovf", ovf_count, 0);
    chk("t3_clr_unf", unf_count, 0);

    out_ready = 1'b0;
    fork
      begin
        send(25'h0800000, 8'h80, 0, 0);
        send(25'h0000100, 8'h80, 0, 0);
        send(25'h1000000, 8'h7F, 0, 0);
      end
      begin
        repeat (3) @(posedge clk);
        #1 chk("t5_in_ready_stall", in_ready, 0);
        chk("t5_out_valid_stall", out_valid, 1);
        chk("t5_held_mant", mantissa_out, 24'h800000);
        out_ready = 1'b1;
      end
    join
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #1 chk("t5_drain", exp_q.size(), 0);

    send(25'h0800000, 8'h80, 0, 0);
    @(posedge clk);
    #1 chk("t5_pre_rst_valid", out_valid, 1);
    rst_n = 1'b0;
    #1 chk("t5_rst_out_valid", out_valid, 0);
    chk("t5_rst_mant", mantissa_out, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(25'h0000100, 8'h80, 0, 0); expect_out("post_rst", 24'h800000, 8'h71, 0, 0, 0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fp_normalizer_pipe.md
Name: fp_normalizer_pipe

Overview:
Parametrised, two-stage pipelined normaliser for the floating-point adder datapath. Sits between the mantissa adder and result packing.
Takes a MANT_W+1-bit raw sum and a biased exponent, then produces a normalised mantissa, an adjusted exponent and overflow/underflow/zero flags under a valid/ready handshake.
Adds saturating overflow/underflow event counters and optional round-to-nearest-even.

Parameters:
MANT_W, 24, mantissa width including hidden bit
EXP_W, 8, biased exponent width
CNT_W, 16, width of each saturating event counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat
sum_result  in  MANT_W+1  raw adder sum; bit MANT_W is the carry
exponent_in  in  EXP_W  biased exponent before normalisation
overflow_flag  in  1  forces the carry path, same as sum_result[MANT_W]=1
in_sticky  in  1  OR of bits shifted out upstream; used only with ROUND_EN
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts the beat
mantissa_out  out  MANT_W  normalised mantissa
exponent_out  out  EXP_W  adjusted exponent
overflow  out  1  result saturated to infinity
underflow  out  1  result subnormal
zero  out  1  sum_result was 0
ovf_count  out  CNT_W  saturating count of overflow results delivered
unf_count  out  CNT_W  saturating count of underflow results delivered
clr_cnt  in  1  synchronous clear of both counters

Behaviour:
- Reset (rst_n=0, asynchronous): all stage valids, out_valid, mantissa_out, exponent_out, flags and counters go to 0. in_ready=1 once reset is released. Reset mid-operation discards in-flight beats.
- Handshake: a beat transfers when valid&ready. in_ready = !s1_valid | s1_adv.
  - s1_adv = !s2_valid | out_ready.
  - Outputs are held stable while out_valid & !out_ready. No beat is dropped or duplicated; order is preserved.
- Latency: 2 cycles from input transfer to out_valid with no backpressure. Throughput is 1 beat/cycle.
- Stage 1 registers the operands and the leading-zero count lz of sum_result[MANT_W-1:0] (0..MANT_W). A zero sum gives lz=MANT_W.
- Stage 2 computes the result in this priority:
  - Zero: sum_result==0 -> mantissa 0, exponent 0, zero=1, other flags 0.
  - Carry: sum_result[MANT_W] | overflow_flag -> mantissa = sum_result[MANT_W:1], exponent = exponent_in+1 evaluated in EXP_W+1 bits.
    - If the result >= all-ones: overflow=1, exponent = all-ones, mantissa 0.
  - Normal: exponent_in > lz -> exponent = exponent_in - lz, mantissa = sum_result[MANT_W-1:0] << lz.
  - Underflow: exponent_in <= lz -> underflow=1, exponent 0.
    - Mantissa = sum_result[MANT_W-1:0] << (exponent_in-1) when exponent_in>=1.
    - Mantissa is unshifted when exponent_in==0.
- Counters: increment when a beat with overflow=1 (resp. underflow=1) transfers on the output. They saturate at all-ones.
  - clr_cnt has priority over increment in the same cycle; the counter reads 0 the next cycle.

Optional Feature:
ROUND_EN.
- Defined: the carry path rounds to nearest even, using guard = sum_result[0] and sticky = in_sticky.
  - Round up when guard & (sticky | mantissa[0]).
  - If the increment carries out of MANT_W bits: mantissa = 1 followed by zeros, exponent +1 more, then the overflow check is reapplied.
  - Adds no extra latency.
- Undefined: the carry path truncates and in_sticky is ignored.

Test Plan:
1. sum_result=25'h0800000, exponent_in=8'h80 -> 2 cycles later mantissa 24'h800000, exponent 8'h80, all flags 0.
2. sum_result=25'h1000000, exponent_in=8'h7F -> mantissa 24'h800000, exponent 8'h80.
3. sum_result=25'h1000000, exponent_in=8'hFE -> overflow=1, exponent 8'hFF, mantissa 0, ovf_count=1. Repeat 2^CNT_W+2 times -> ovf_count saturates at all-ones. Assert clr_cnt -> 0.
4. sum_result=25'h0000100 (lz=15), exponent_in=8'h0A -> underflow=1, exponent 0, mantissa 24'h020000, unf_count increments.
5. Stream 3 beats with out_ready=0 for 3 cycles -> in_ready drops after 2 accepted beats. Releasing out_ready delivers all 3 in order, with outputs stable while stalled. Assert rst_n mid-stream -> out_valid=0 immediately.
6. sum_result=25'h1FFFFFF, exponent_in=8'h80, in_sticky=0:
   - With ROUND_EN: mantissa 24'h800000, exponent 8'h82.
   - Without ROUND_EN: mantissa 24'hFFFFFF, exponent 8'h81.
